branch_pred_unit: RTL and testbench
===================================

Name: branch_pred_unit

Overview:
- Parametrised fetch-stage branch prediction unit for the pipelined RV32I core.
- Replaces the fixed 10-bit-history local BHT plus untagged BTB pair.
- Contains a tagged direct-mapped BTB, a gshare PHT of 2-bit counters, and a speculative global history register (GHR) with repair on mispredict.
- Looked up by IF every cycle; trained by EX when a branch or jump resolves.

Parameters:
- XLEN, 32, address/target width.
- BTB_ENTRIES, 64, BTB depth; power of 2.
- PHT_ENTRIES, 1024, PHT depth; power of 2; log2(PHT_ENTRIES) >= GHR_BITS.
- GHR_BITS, 10, global history length.
- TAG_BITS, 8, partial tag stored per BTB entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lookup_valid  in  1  IF requests prediction for lookup_pc
- lookup_pc  in  XLEN  fetch PC
- stall  in  1  IF stalled; hold outputs and GHR
- pred_valid  out  1  prediction outputs valid this cycle
- pred_taken  out  1  predicted redirect
- pred_target  out  XLEN  redirect target (0 when not taken)
- pred_ghr  out  GHR_BITS  GHR snapshot used for this lookup; travels down the pipe
- upd_valid  in  1  EX resolves a control instruction
- upd_pc  in  XLEN  resolved instruction PC
- upd_is_jump  in  1  1 = jal/jalr, 0 = conditional branch
- upd_taken  in  1  actual outcome (jumps always 1)
- upd_target  in  XLEN  actual target
- upd_ghr  in  GHR_BITS  pred_ghr carried with the instruction
- upd_mispredict  in  1  direction or target mispredicted; qualified by upd_valid

Behaviour:
- Reset (async, rst_n=0): all BTB valid bits 0; PHT counters 2'b01 (weakly not-taken); GHR 0; pred_valid/pred_taken/pred_target/pred_ghr 0. A reset mid-stream discards any in-flight prediction.
- Indexing:
  - btb_idx = pc[log2(BTB_ENTRIES)+1:2]; tag = next TAG_BITS bits above the index.
  - pht_idx = pc[log2(PHT_ENTRIES)+1:2] XOR zero-extended GHR (upd_ghr on the update path).
- Lookup latency 1 cycle.
  - Lookup is accepted when lookup_valid & ~stall & ~(upd_valid & upd_mispredict).
  - Cycle after acceptance: pred_valid=1.
  - hit = valid & tag match. pred_taken = hit & (jump | pht[idx][1]).
  - pred_target = stored target if pred_taken, else 0. pred_ghr = GHR value before the speculative shift.
- No accepted lookup (and no stall) -> pred_valid=0 next cycle.
- stall=1 -> all outputs and GHR hold.
- Speculative GHR: on an accepted lookup that hits a branch-type entry, GHR <= {GHR[GHR_BITS-2:0], pred_taken}. Jumps and misses do not shift.
- Repair: upd_valid & upd_mispredict -> GHR <= upd_is_jump ? upd_ghr : {upd_ghr[GHR_BITS-2:0], upd_taken}. The same-cycle lookup is squashed (pred_valid=0 next cycle). Repair has priority over the speculative shift and over stall.
- Training, on upd_valid:
  - Branch: PHT[upd idx] saturating ++ if taken, -- if not; saturates at 2'b11 and 2'b00.
  - Jump: PHT untouched.
  - BTB write {valid=1, tag, target, type} when upd_taken. A not-taken branch leaves the BTB unchanged, including a hit entry.
- Same-cycle lookup/update to the same index: lookup sees the pre-update value (read-before-write). The write takes effect next cycle.
- Aliased tags overwrite in place (direct-mapped); there is no replacement state.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- Defined: adds outputs perf_lookups, perf_updates, perf_mispredicts (32-bit each).
  - Counters increment on accepted lookup, on upd_valid, and on upd_valid & upd_mispredict respectively.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- rv32i_types gains:
  - enum bpu_btype_t {BT_BRANCH, BT_JUMP}
  - struct btb_entry_t {valid, tag, target, btype}
  - constant PHT_RESET_VAL = 2'b01
- Sub-module bpu_btb (tagged storage, read port and write port, valid-clear on reset). PHT and GHR stay in the top module.

Test Plan:
- Reset, then lookup 0x00000100 -> pred_valid=1, pred_taken=0, pred_target=0, pred_ghr=0.
- Train branch at 0x100, target 0x80, taken 3 times with upd_ghr=0; lookup 0x100 with GHR=0 -> pred_taken=1, pred_target=0x80, GHR shifts to 0x001.
- jal at 0x200 to 0x400 updated once -> next lookup 0x200 predicts taken to 0x400, GHR unchanged. 0x200+BTB_ENTRIES*4 (different tag) -> miss, not taken.
- Mispredict with upd_ghr=0x155, upd_taken=0, same cycle as lookup_valid -> GHR=0x2AA next cycle, pred_valid=0.
- Counter saturation: 5 taken updates, then 1 not-taken -> counter 2'b10, still predicts taken. 3 more not-taken -> 2'b00, stays 2'b00 on a further not-taken.
- stall held 3 cycles after a hit -> outputs and GHR constant. Assert rst_n low mid-stall -> all outputs 0 and the BTB misses afterwards.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types; this slice carries the branch-prediction entries.
package rv32i_types;

  localparam int unsigned RV_XLEN      = 32;
  localparam int unsigned BPU_TAG_BITS = 8;

  typedef enum logic {
    BT_BRANCH = 1'b0,
    BT_JUMP   = 1'b1
  } bpu_btype_t;

  typedef struct packed {
    logic                    valid;
    logic [BPU_TAG_BITS-1:0] tag;
    logic [RV_XLEN-1:0]      target;
    bpu_btype_t              btype;
  } btb_entry_t;

  localparam logic [1:0] PHT_RESET_VAL = 2'b01;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// Tagged direct-mapped branch target buffer: one combinational read port, one write port.
module bpu_btb
  import rv32i_types::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
  input  logic [TAG_BITS-1:0]        i_rd_tag,
  output logic                       o_rd_hit,
  output logic [XLEN-1:0]            o_rd_target,
  output bpu_btype_t                 o_rd_btype,
  input  logic                       i_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0]        i_wr_tag,
  input  logic [XLEN-1:0]            i_wr_target,
  input  bpu_btype_t                 i_wr_btype
);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  bpu_btype_t          r_btype  [ENTRIES];

  // Only the valid bits need reset; payload is qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
      r_btype[i_wr_idx]  <= i_wr_btype;
    end
  end

  assign o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_target = r_target[i_rd_idx];
  assign o_rd_btype  = r_btype[i_rd_idx];

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch-stage predictor: tagged BTB, gshare PHT and speculative GHR with mispredict repair.
// Optional performance counters are enabled with `define BPU_PERF_CNT_EN.
module branch_pred_unit
  import rv32i_types::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 1024,
  parameter int unsigned GHR_BITS    = 10,
  parameter int unsigned TAG_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_lookup_valid,
  input  logic [XLEN-1:0]     i_lookup_pc,
  input  logic                i_stall,
  output logic                o_pred_valid,
  output logic                o_pred_taken,
  output logic [XLEN-1:0]     o_pred_target,
  output logic [GHR_BITS-1:0] o_pred_ghr,
  input  logic                i_upd_valid,
  input  logic [XLEN-1:0]     i_upd_pc,
  input  logic                i_upd_is_jump,
  input  logic                i_upd_taken,
  input  logic [XLEN-1:0]     i_upd_target,
  input  logic [GHR_BITS-1:0] i_upd_ghr,
  input  logic                i_upd_mispredict
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]         o_perf_lookups,
  output logic [31:0]         o_perf_updates,
  output logic [31:0]         o_perf_mispredicts
`endif
);

  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);

  logic                r_pred_valid, r_pred_taken;
  logic [XLEN-1:0]     r_pred_target;
  logic [GHR_BITS-1:0] r_pred_ghr, r_ghr;
  logic [1:0]          r_pht [PHT_ENTRIES];

  logic                w_repair, w_accept, w_hit, w_pred_taken, w_pht_wr;
  logic [XLEN-1:0]     w_btb_target;
  bpu_btype_t          w_btb_btype;
  logic [PHT_IW-1:0]   w_lk_pht_idx, w_upd_pht_idx;
  logic                w_unused_pc;

  assign w_repair = i_upd_valid && i_upd_mispredict;
  assign w_accept = i_lookup_valid && !i_stall && !w_repair;

  assign w_lk_pht_idx  = i_lookup_pc[PHT_IW+1:2] ^ PHT_IW'(r_ghr);
  assign w_upd_pht_idx = i_upd_pc[PHT_IW+1:2] ^ PHT_IW'(i_upd_ghr);
  assign w_unused_pc   = ^{i_lookup_pc, i_upd_pc};

  bpu_btb #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (i_lookup_pc[BTB_IW+1:2]),
    .i_rd_tag    (i_lookup_pc[BTB_IW+TAG_BITS+1:BTB_IW+2]),
    .o_rd_hit    (w_hit),
    .o_rd_target (w_btb_target),
    .o_rd_btype  (w_btb_btype),
    .i_wr_en     (i_upd_valid && i_upd_taken),
    .i_wr_idx    (i_upd_pc[BTB_IW+1:2]),
    .i_wr_tag    (i_upd_pc[BTB_IW+TAG_BITS+1:BTB_IW+2]),
    .i_wr_target (i_upd_target),
    .i_wr_btype  (i_upd_is_jump ? BT_JUMP : BT_BRANCH)
  );

  assign w_pred_taken = w_hit && ((w_btb_btype == BT_JUMP) || r_pht[w_lk_pht_idx][1]);
  assign w_pht_wr     = i_upd_valid && !i_upd_is_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) r_pht[i] <= PHT_RESET_VAL;
    end else if (w_pht_wr) begin
      r_pht[w_upd_pht_idx] <= sat_ctr_next(r_pht[w_upd_pht_idx], i_upd_taken);
    end
  end

  // Repair wins over both stall and the speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      r_ghr <= i_upd_is_jump ? i_upd_ghr : {i_upd_ghr[GHR_BITS-2:0], i_upd_taken};
    end else if (w_accept && w_hit && (w_btb_btype == BT_BRANCH)) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], w_pred_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      r_pred_ghr    <= '0;
    end else if (w_repair || !i_stall) begin
      r_pred_valid  <= w_accept;
      r_pred_taken  <= w_accept && w_pred_taken;
      r_pred_target <= (w_accept && w_pred_taken) ? w_btb_target : '0;
      r_pred_ghr    <= w_accept ? r_ghr : '0;
    end
  end

  assign o_pred_valid  = r_pred_valid;
  assign o_pred_taken  = r_pred_taken;
  assign o_pred_target = r_pred_target;
  assign o_pred_ghr    = r_pred_ghr;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] r_perf_lookups, r_perf_updates, r_perf_mispredicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lookups     <= '0;
      r_perf_updates     <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_accept && (r_perf_lookups != '1)) r_perf_lookups <= r_perf_lookups + 32'd1;
      if (i_upd_valid && (r_perf_updates != '1)) r_perf_updates <= r_perf_updates + 32'd1;
      if (w_repair && (r_perf_mispredicts != '1)) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign o_perf_lookups     = r_perf_lookups;
  assign o_perf_updates     = r_perf_updates;
  assign o_perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed scoreboard bench for branch_pred_unit (default parameters).
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid, stall, upd_valid, upd_is_jump, upd_taken, upd_mispredict;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic [9:0]  upd_ghr;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic [9:0]  pred_ghr;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lookups, perf_updates, perf_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    int unsigned mode;  // 0 no check, 1 valid only, 2 all outputs
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic [9:0]  ghr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  branch_pred_unit u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_lookup_valid   (lookup_valid),
    .i_lookup_pc      (lookup_pc),
    .i_stall          (stall),
    .o_pred_valid     (pred_valid),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .o_pred_ghr       (pred_ghr),
    .i_upd_valid      (upd_valid),
    .i_upd_pc         (upd_pc),
    .i_upd_is_jump    (upd_is_jump),
    .i_upd_taken      (upd_taken),
    .i_upd_target     (upd_target),
    .i_upd_ghr        (upd_ghr),
    .i_upd_mispredict (upd_mispredict)
`ifdef BPU_PERF_CNT_EN
    ,
    .o_perf_lookups     (perf_lookups),
    .o_perf_updates     (perf_updates),
    .o_perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(pred_valid), 64'd0);
    check_eq({tag, "_taken"}, 64'(pred_taken), 64'd0);
    check_eq({tag, "_target"}, 64'(pred_target), 64'd0);
    check_eq({tag, "_ghr"}, 64'(pred_ghr), 64'd0);
  endtask

  // Drive one cycle, queue the expectation, then compare once the DUT has produced it.
  task automatic cyc(input string tag, input logic lv, input logic [31:0] lpc, input logic st,
                     input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
                     input logic [31:0] utgt, input logic [9:0] ughr, input logic um,
                     input int unsigned mode, input logic ev, input logic et,
                     input logic [31:0] etgt, input logic [9:0] eghr);
    exp_t e;
    lookup_valid = lv; lookup_pc = lpc; stall = st;
    upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut;
    upd_target = utgt; upd_ghr = ughr; upd_mispredict = um;
    sb_q.push_back('{tag: tag, mode: mode, v: ev, t: et, tgt: etgt, ghr: eghr});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.mode >= 1) check_eq({e.tag, "_valid"}, 64'(pred_valid), 64'(e.v));
    if (e.mode == 2) begin
      check_eq({e.tag, "_taken"}, 64'(pred_taken), 64'(e.t));
      check_eq({e.tag, "_target"}, 64'(pred_target), 64'(e.tgt));
      check_eq({e.tag, "_ghr"}, 64'(pred_ghr), 64'(e.ghr));
    end
    lookup_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; stall = 1'b0;
  endtask

  task automatic lk(input string tag, input logic [31:0] pc, input logic et,
                    input logic [31:0] etgt, input logic [9:0] eghr);
    cyc(tag, 1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 10'd0, 1'b0,
        2, 1'b1, et, etgt, eghr);
  endtask

  task automatic up(input logic [31:0] pc, input logic j, input logic t,
                    input logic [31:0] tgt, input logic [9:0] ghr, input logic m);
    cyc("upd", 1'b0, 32'd0, 1'b0, 1'b1, pc, j, t, tgt, ghr, m, 1, 1'b0, 1'b0, 32'd0, 10'd0);
  endtask

  // Branch mispredict with zero history and not-taken outcome: GHR becomes 0.
  task automatic ghr_clear();
    up(32'h900, 1'b0, 1'b0, 32'd0, 10'd0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_ghr = '0; upd_mispredict = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs_zero("reset");

    lk("miss0", 32'h100, 1'b0, 32'h0, 10'h0);
    repeat (3) up(32'h100, 1'b0, 1'b1, 32'h80, 10'h0, 1'b0);
    lk("br_taken", 32'h100, 1'b1, 32'h80, 10'h0);
    lk("br_ghr1", 32'h100, 1'b0, 32'h0, 10'h1);

    up(32'h200, 1'b1, 1'b1, 32'h400, 10'h0, 1'b0);
    lk("jal", 32'h200, 1'b1, 32'h400, 10'h2);
    lk("jal_noshift", 32'h200, 1'b1, 32'h400, 10'h2);
    lk("alias_miss", 32'h300, 1'b0, 32'h0, 10'h2);

    // Read-before-write on a same-cycle lookup and update to the same entry.
    cyc("rbw", 1'b1, 32'h40C, 1'b0, 1'b1, 32'h40C, 1'b1, 1'b1, 32'h800, 10'h0, 1'b0,
        2, 1'b1, 1'b0, 32'h0, 10'h2);
    lk("rbw_hit", 32'h40C, 1'b1, 32'h800, 10'h2);

    cyc("squash", 1'b1, 32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 10'h155, 1'b1,
        1, 1'b0, 1'b0, 32'h0, 10'h0);
    lk("repair", 32'h300, 1'b0, 32'h0, 10'h2AA);

    ghr_clear();
    repeat (5) up(32'h604, 1'b0, 1'b1, 32'h640, 10'h0, 1'b0);
    up(32'h604, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
    lk("sat_hi", 32'h604, 1'b1, 32'h640, 10'h0);
    ghr_clear();
    repeat (4) up(32'h604, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
    lk("sat_lo", 32'h604, 1'b0, 32'h0, 10'h0);
    up(32'h604, 1'b0, 1'b1, 32'h640, 10'h0, 1'b0);
    lk("sat_lo_inc", 32'h604, 1'b0, 32'h0, 10'h0);

    repeat (2) up(32'h108, 1'b0, 1'b1, 32'h180, 10'h0, 1'b0);
    lk("pre_stall", 32'h200, 1'b1, 32'h400, 10'h0);
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1'b1, 32'h108, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0,
          2, 1'b1, 1'b1, 32'h400, 10'h0);
    end
    lk("post_stall", 32'h200, 1'b1, 32'h400, 10'h0);
    lk("br108", 32'h108, 1'b1, 32'h180, 10'h0);
    lk("ghr_after", 32'h200, 1'b1, 32'h400, 10'h1);

    // Reset asserted while stalled.
    lookup_valid = 1'b1; lookup_pc = 32'h200; stall = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_outputs_zero("rst_stall");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lookup_valid = 1'b0; stall = 1'b0;
    lk("rst_miss_jal", 32'h200, 1'b0, 32'h0, 10'h0);
    lk("rst_miss_br", 32'h108, 1'b0, 32'h0, 10'h0);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
